// File: rtl/counter_ctrl.sv
// counter_ctrl: debounced push-button front end driving a prescaled
// modulo-(MAX+1) up/down counter with a RUN/STOP state machine.
module counter_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 9,
  parameter int PRESCALE  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir,
  output logic             wrap
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX);
  typedef enum logic {STOP, RUN} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync2_q, db_q, db_d, dbp_q, tick;
  logic [CW-1:0] dbc_q [3];
  logic [CW-1:0] dbc_d [3];
  logic [PW-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic dir_q, dir_d, wrap_q, wrap_d;
  logic run_tick, dir_tick, clr_tick, step, stop, do_step;
  // Bit order for every per-button vector: 0 = run, 1 = dir, 2 = clr.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = (sync2_q[i] == db_q[i] || dbc_q[i] == DB_LAST) ? '0 : dbc_q[i] + 1'b1;
      db_d[i]  = (sync2_q[i] != db_q[i] && dbc_q[i] == DB_LAST) ? sync2_q[i] : db_q[i];
    end
  end
  assign tick     = db_q & ~dbp_q;
  assign run_tick = tick[0];
  assign dir_tick = tick[1];
  assign clr_tick = tick[2];
  assign step     = state_q == RUN && pre_q == PS_LAST;
  assign stop     = run_tick && state_q == RUN;
  assign do_step  = step && !clr_tick && !stop;
  always_comb begin
    state_d = run_tick ? (state_q == RUN ? STOP : RUN) : state_q;
    dir_d   = dir_q ^ dir_tick;
    pre_d   = (clr_tick || stop || state_q == STOP || step) ? '0 : pre_q + 1'b1;
    wrap_d  = do_step && (dir_q ? count_q == '0 : count_q == CMAX);
    count_d = clr_tick ? '0 :
              !do_step ? count_q :
              dir_q ? (count_q == '0 ? CMAX : count_q - 1'b1) :
                      (count_q == CMAX ? '0 : count_q + 1'b1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      dbc_q   <= '{default: '0};
      state_q <= STOP;
      pre_q   <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sync1_q <= {btn_clr, btn_dir, btn_run};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count   = count_q;
  assign running = state_q == RUN;
  assign dir     = dir_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench with PRESCALE=4, DB_CYCLES=3, MAX=9;
// t counts falling edges from the edge on which the first run press lands.
module tb_counter_ctrl;
  logic clk = 1'b0;
  logic rst, btn_run, btn_dir, btn_clr;
  logic [3:0] count;
  logic running, dir, wrap;
  int checks = 0;
  int failures = 0;
  int t = 0;
  counter_ctrl #(.WIDTH(4), .MAX(9), .PRESCALE(4), .DB_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_dir(btn_dir), .btn_clr(btn_clr),
    .count(count), .running(running), .dir(dir), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, act, exp, t);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask
  task automatic at(input int tt);
    adv(tt - t);
  endtask
  initial begin
    rst = 1'b1;
    btn_run = 1'b0;
    btn_dir = 1'b0;
    btn_clr = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    adv(100);
    check("idle_count", 32'(count), 0);
    check("idle_running", 32'(running), 0);
    btn_run = 1'b1;
    adv(2);
    btn_run = 1'b0;
    adv(10);
    check("glitch_running", 32'(running), 0);
    check("glitch_count", 32'(count), 0);
    btn_run = 1'b1;
    adv(5);
    check("press_early", 32'(running), 0);
    adv(1);
    check("press_run", 32'(running), 1);
    t = 0;
    btn_run = 1'b0;
    for (int i = 0; i < 41; i++) begin
      adv(1);
      check("up_count", 32'(count), 32'((t / 4) % 10));
      check("up_wrap", 32'(wrap), 32'(t == 40));
    end
    at(46); btn_dir = 1'b1;
    at(51); check("dir_before", 32'(dir), 0); check("count_before_dir", 32'(count), 2);
    at(52); check("dir_toggled", 32'(dir), 1); check("dir_step_old", 32'(count), 3);
    btn_dir = 1'b0;
    at(56); check("down_2", 32'(count), 2);
    at(60); check("down_1", 32'(count), 1);
    at(64); check("down_0", 32'(count), 0); check("down_nowrap", 32'(wrap), 0);
    at(67); check("down_0_hold", 32'(count), 0);
    at(68); check("down_9", 32'(count), 9); check("down_wrap", 32'(wrap), 1);
    at(69); check("down_wrap_end", 32'(wrap), 0);
    at(72); check("down_8", 32'(count), 8);
    at(73); btn_dir = 1'b1;
    at(79); check("dir_up", 32'(dir), 0); check("count_7", 32'(count), 7);
    at(80); btn_dir = 1'b0; check("up_8", 32'(count), 8);
    at(82); btn_clr = 1'b1;
    at(84); check("up_9", 32'(count), 9);
    at(87); check("pre_clr_count", 32'(count), 9); check("pre_clr_wrap", 32'(wrap), 0);
    at(88); check("clr_count", 32'(count), 0); check("clr_wrap", 32'(wrap), 0); check("clr_running", 32'(running), 1);
    at(89); btn_clr = 1'b0; check("clr_wrap_next", 32'(wrap), 0); check("clr_hold", 32'(count), 0);
    at(91); check("clr_no_early_step", 32'(count), 0);
    at(92); check("clr_next_step", 32'(count), 1);
    at(98); btn_run = 1'b1;
    at(103); check("stop_before", 32'(running), 1); check("stop_before_count", 32'(count), 3);
    at(104); check("stop_running", 32'(running), 0); check("stop_step_dropped", 32'(count), 3);
    at(105); btn_run = 1'b0;
    at(154); check("stop_hold_count", 32'(count), 3); check("stop_hold_running", 32'(running), 0);
    at(160); btn_run = 1'b1;
    at(165); check("restart_early", 32'(running), 0);
    at(166); check("restart_run", 32'(running), 1); check("restart_count", 32'(count), 3);
    at(167); btn_run = 1'b0;
    at(169); check("restart_no_early", 32'(count), 3);
    at(170); check("restart_step", 32'(count), 4);
    at(174); check("before_rst", 32'(count), 5);
    at(175); rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 0);
    check("midrst_running", 32'(running), 0);
    check("midrst_dir", 32'(dir), 0);
    check("midrst_wrap", 32'(wrap), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
